// File: rtl/ma_dot_seq.sv
// Dot-product sequencer: seeds the MAC with a bias, streams operand pairs, drains the MAC pipeline, returns p.
// Optional feature: define MA_DOT_SEQ_SAT_EN for signed saturation of the result (default is truncation).
module ma_dot_seq #(
    parameter int ASIZE   = 18,
    parameter int BSIZE   = 18,
    parameter int PSIZE   = 96,
    parameter int LEN_W   = 10,
    parameter int MAC_LAT = 1,
    parameter int OUT_W   = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [PSIZE-1:0] bias,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ASIZE-1:0] in_a,
    input  logic [BSIZE-1:0] in_b,
    output logic [ASIZE-1:0] mac_a,
    output logic [BSIZE-1:0] mac_b,
    output logic             mac_reload,
    output logic [PSIZE-1:0] mac_acc_init,
    input  logic [PSIZE-1:0] mac_p,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [OUT_W-1:0] res_data,
    output logic             res_sat
);

    localparam int DW = $clog2(MAC_LAT + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_OUT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] cnt;
    logic [DW-1:0]    drain_cnt;
    logic [PSIZE-1:0] acc_init_q;
    logic [OUT_W-1:0] res_data_q;
    logic             res_sat_q;
    logic [OUT_W-1:0] res_next;
    logic             sat_next;
    logic             accept;
    logic             drain_last;

    assign accept     = (state == S_RUN) && in_valid;
    assign drain_last = (state == S_DRAIN) && (drain_cnt == DW'(MAC_LAT));

`ifdef MA_DOT_SEQ_SAT_EN
    // The value fits when every bit above the result sign bit matches it.
    logic [PSIZE-OUT_W:0] p_upper;
    logic                 p_fits;

    assign p_upper = mac_p[PSIZE-1:OUT_W-1];
    assign p_fits  = (&p_upper) | ~(|p_upper);

    always_comb begin
        res_next = mac_p[OUT_W-1:0];
        sat_next = 1'b0;
        if (!p_fits) begin
            sat_next = 1'b1;
            res_next = mac_p[PSIZE-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                      : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end
`else
    assign res_next = mac_p[OUT_W-1:0];
    assign sat_next = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            drain_cnt  <= '0;
            acc_init_q <= '0;
            res_data_q <= '0;
            res_sat_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && start) begin
                cnt        <= len;
                acc_init_q <= bias;
            end else if (accept) begin
                cnt <= cnt - 1'b1;
            end
            drain_cnt <= (state == S_DRAIN) ? drain_cnt + 1'b1 : '0;
            // p is sampled on the edge that closes the final drain cycle
            if (drain_last) begin
                res_data_q <= res_next;
                res_sat_q  <= sat_next;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = (cnt == '0) ? S_DRAIN : S_RUN;
            S_RUN:   if (accept && cnt == LEN_W'(1)) state_nxt = S_DRAIN;
            S_DRAIN: if (drain_last) state_nxt = S_OUT;
            S_OUT:   if (res_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operands are zero whenever no pair is accepted so the free-running MAC adds nothing.
    always_comb begin
        busy       = (state != S_IDLE);
        in_ready   = 1'b0;
        mac_a      = '0;
        mac_b      = '0;
        mac_reload = 1'b0;
        res_valid  = 1'b0;
        case (state)
            S_LOAD: mac_reload = 1'b1;
            S_RUN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mac_a = in_a;
                    mac_b = in_b;
                end
            end
            S_OUT:   res_valid = 1'b1;
            default: ;
        endcase
    end

    assign mac_acc_init = acc_init_q;
    assign res_data     = res_data_q;
    assign res_sat      = res_sat_q;

endmodule

// File: tb/tb_ma_dot_seq.sv
// Bench for ma_dot_seq: behavioural MAC stand-in (one output register), directed and random jobs vs a sum-of-products model.
// Honours MA_DOT_SEQ_SAT_EN the same way as the design.
module tb_ma_dot_seq;

    localparam int ASIZE   = 18;
    localparam int BSIZE   = 18;
    localparam int PSIZE   = 96;
    localparam int LEN_W   = 10;
    localparam int MAC_LAT = 1;
    localparam int OUT_W   = 48;
    localparam int NV      = 11;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic [PSIZE-1:0] bias;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [ASIZE-1:0] in_a;
    logic [BSIZE-1:0] in_b;
    logic [ASIZE-1:0] mac_a;
    logic [BSIZE-1:0] mac_b;
    logic             mac_reload;
    logic [PSIZE-1:0] mac_acc_init;
    logic [PSIZE-1:0] mac_p;
    logic             res_valid;
    logic             res_ready;
    logic [OUT_W-1:0] res_data;
    logic             res_sat;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int reloadTotal = 0;
    int readyTotal = 0;

    typedef struct {
        int                     len;
        logic [PSIZE-1:0]       bias;
        int                     gap;
        int                     hold;
        logic [7:0][ASIZE-1:0]  a;
        logic [7:0][BSIZE-1:0]  b;
        logic [OUT_W-1:0]       expData;
        logic                   expSat;
    } vec_t;

    vec_t vecs [NV];
    vec_t afterReset;

    ma_dot_seq #(
        .ASIZE(ASIZE), .BSIZE(BSIZE), .PSIZE(PSIZE),
        .LEN_W(LEN_W), .MAC_LAT(MAC_LAT), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .bias(bias), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mac_a(mac_a), .mac_b(mac_b), .mac_reload(mac_reload), .mac_acc_init(mac_acc_init),
        .mac_p(mac_p), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_sat(res_sat)
    );

    always #5 clk = ~clk;

    // Stand-in for the MAC core: accumulator plus one output register stage.
    logic signed [PSIZE-1:0] macAcc;
    logic signed [35:0]      macProd;
    assign macProd = $signed(mac_a) * $signed(mac_b);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            macAcc <= '0;
            mac_p  <= '0;
        end else begin
            macAcc <= mac_reload ? $signed(mac_acc_init) : macAcc + macProd;
            mac_p  <= macAcc;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mac_reload) reloadTotal <= reloadTotal + 1;
        if (in_ready) readyTotal <= readyTotal + 1;
    end

    task automatic checkOutput(input string nm, input logic [PSIZE-1:0] act, input logic [PSIZE-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Dot product plus bias, then clipped or truncated to the result width.
    function automatic void refModel(input vec_t v, output logic [OUT_W-1:0] d, output logic s);
        logic signed [PSIZE-1:0] sum;
        logic signed [PSIZE-1:0] maxv;
        logic signed [PSIZE-1:0] minv;
        sum  = $signed(v.bias);
        maxv = $signed({{(PSIZE-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
        minv = $signed({{(PSIZE-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}});
        for (int i = 0; i < v.len; i++)
            sum = sum + $signed(v.a[i]) * $signed(v.b[i]);
`ifdef MA_DOT_SEQ_SAT_EN
        s = 1'b1;
        if (sum > maxv) d = maxv[OUT_W-1:0];
        else if (sum < minv) d = minv[OUT_W-1:0];
        else begin
            d = sum[OUT_W-1:0];
            s = 1'b0;
        end
`else
        d = sum[OUT_W-1:0];
        s = 1'b0;
`endif
    endfunction

    task automatic applyStimulus(input int id, input vec_t v);
        int idx = 0;
        int gapLeft = 0;
        int budget = 0;
        int startCyc;
        int acceptCyc;
        int opViol = 0;
        int nrViol = 0;
        int holdViol = 0;
        int rel0;
        int rdy0;
        bit seen = 0;
        logic [OUT_W-1:0] got;
        logic gotSat;

        rel0 = reloadTotal;
        rdy0 = readyTotal;
        @(negedge clk);
        start = 1'b1;
        len = LEN_W'(v.len);
        bias = v.bias;
        res_ready = 1'b0;
        startCyc = cyc;
        acceptCyc = cyc;

        while (idx < v.len && budget < 200) begin
            @(negedge clk);
            start = 1'b0;
            budget++;
            if (gapLeft > 0) begin
                in_valid = 1'b0;
                in_a = ASIZE'($urandom) | ASIZE'(1);
                in_b = BSIZE'($urandom) | BSIZE'(1);
                gapLeft--;
            end else begin
                in_valid = 1'b1;
                in_a = v.a[idx];
                in_b = v.b[idx];
            end
            #1;
            if (in_valid && in_ready) begin
                if (mac_a !== in_a || mac_b !== in_b) opViol++;
                acceptCyc = cyc;
                idx++;
                gapLeft = v.gap;
            end else if (mac_a !== '0 || mac_b !== '0) begin
                opViol++;
            end
        end
        if (idx < v.len) begin
            total++;
            bad++;
            $display("[TB] FAIL job%0d feed: accepted %0d of %0d pairs before timeout", id, idx, v.len);
        end

        // Offer junk operands while not in RUN; none may reach the MAC.
        budget = 0;
        while (!seen && budget < 100) begin
            @(negedge clk);
            start = 1'b0;
            budget++;
            in_valid = 1'b1;
            in_a = ASIZE'($urandom) | ASIZE'(1);
            in_b = BSIZE'($urandom) | BSIZE'(1);
            #1;
            if (in_ready || mac_a !== '0 || mac_b !== '0) nrViol++;
            if (res_valid) seen = 1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("[TB] FAIL job%0d result: res_valid never rose, required within 100 cycles", id);
        end else begin
            checkOutput($sformatf("job%0d latency", id), PSIZE'(cyc - (v.len == 0 ? startCyc : acceptCyc)),
                        PSIZE'(v.len == 0 ? MAC_LAT + 3 : MAC_LAT + 2));
            got = res_data;
            gotSat = res_sat;
            checkOutput($sformatf("job%0d res_data", id), PSIZE'(got), PSIZE'(v.expData));
            checkOutput($sformatf("job%0d res_sat", id), PSIZE'(gotSat), PSIZE'(v.expSat));
        end

        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            start = (h == 2);
            len = LEN_W'(3);
            #1;
            if (!res_valid || res_data !== got || res_sat !== gotSat || !busy) holdViol++;
        end
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        checkOutput($sformatf("job%0d busy after handshake", id), PSIZE'(busy), '0);
        checkOutput($sformatf("job%0d res_valid after handshake", id), PSIZE'(res_valid), '0);
        checkOutput($sformatf("job%0d reload pulses", id), PSIZE'(reloadTotal - rel0), PSIZE'(1));
        checkOutput($sformatf("job%0d operand routing", id), PSIZE'(opViol), '0);
        checkOutput($sformatf("job%0d idle operands", id), PSIZE'(nrViol), '0);
        if (v.hold > 0)
            checkOutput($sformatf("job%0d hold", id), PSIZE'(holdViol), '0);
        if (v.len == 0)
            checkOutput($sformatf("job%0d in_ready cycles", id), PSIZE'(readyTotal - rdy0), '0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " busy"}, PSIZE'(busy), '0);
        checkOutput({tag, " in_ready"}, PSIZE'(in_ready), '0);
        checkOutput({tag, " mac_a"}, PSIZE'(mac_a), '0);
        checkOutput({tag, " mac_b"}, PSIZE'(mac_b), '0);
        checkOutput({tag, " mac_reload"}, PSIZE'(mac_reload), '0);
        checkOutput({tag, " mac_acc_init"}, mac_acc_init, '0);
        checkOutput({tag, " res_valid"}, PSIZE'(res_valid), '0);
        checkOutput({tag, " res_data"}, PSIZE'(res_data), '0);
        checkOutput({tag, " res_sat"}, PSIZE'(res_sat), '0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int accepts;
        int budget;

        // Directed jobs: the four-pair example, with gaps, empty job, long hold, wrap/saturation.
        for (int i = 0; i < NV; i++) begin
            vecs[i].a = '0;
            vecs[i].b = '0;
            vecs[i].gap = 0;
            vecs[i].hold = 0;
            vecs[i].expSat = 1'b0;
        end
        vecs[0].len = 4;
        vecs[0].bias = '0;
        vecs[0].a[0] = ASIZE'(1);  vecs[0].b[0] = BSIZE'(2);
        vecs[0].a[1] = ASIZE'(3);  vecs[0].b[1] = BSIZE'(4);
        vecs[0].a[2] = ASIZE'(-5); vecs[0].b[2] = BSIZE'(6);
        vecs[0].a[3] = ASIZE'(7);  vecs[0].b[3] = BSIZE'(-8);
        vecs[0].expData = OUT_W'(-72);
        vecs[1] = vecs[0];
        vecs[1].gap = 2;
        vecs[2].len = 0;
        vecs[2].bias = PSIZE'(100);
        vecs[2].expData = OUT_W'(100);
        vecs[3] = vecs[0];
        vecs[3].hold = 10;
        vecs[4].len = 1;
        vecs[4].bias = 96'h7FFF_FFFF_FFFF;
        vecs[4].a[0] = ASIZE'(1);
        vecs[4].b[0] = BSIZE'(1);
`ifdef MA_DOT_SEQ_SAT_EN
        vecs[4].expData = 48'h7FFF_FFFF_FFFF;
        vecs[4].expSat = 1'b1;
`else
        vecs[4].expData = 48'h8000_0000_0000;
        vecs[4].expSat = 1'b0;
`endif
        for (int i = 5; i < NV; i++) begin
            logic [39:0] r;
            vecs[i].len = $urandom_range(1, 8);
            vecs[i].gap = $urandom_range(0, 1);
            vecs[i].hold = $urandom_range(0, 3);
            for (int k = 0; k < 8; k++) begin
                vecs[i].a[k] = ASIZE'($urandom);
                vecs[i].b[k] = BSIZE'($urandom);
            end
            r = {8'($urandom), 32'($urandom)};
            if (i % 3 == 0) vecs[i].bias = 96'h7FFF_FFFF_F000 + PSIZE'(r[11:0]);
            else if (i % 3 == 1) vecs[i].bias = 96'hFFFF_FFFF_FFFF_8000_0000_0100 - PSIZE'(r[11:0]);
            else vecs[i].bias = {{(PSIZE-40){r[39]}}, r};
            refModel(vecs[i], vecs[i].expData, vecs[i].expSat);
        end

        rst = 1'b1;
        start = 1'b0;
        len = '0;
        bias = '0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkResetOutputs("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < NV; i++) applyStimulus(i, vecs[i]);

        // Reset in the middle of RUN: two of five pairs taken, then abort.
        @(negedge clk);
        start = 1'b1;
        len = LEN_W'(5);
        bias = PSIZE'(7);
        accepts = 0;
        budget = 0;
        while (accepts < 2 && budget < 50) begin
            @(negedge clk);
            start = 1'b0;
            budget++;
            in_valid = 1'b1;
            in_a = ASIZE'(2);
            in_b = BSIZE'(2);
            #1;
            if (in_ready) accepts++;
        end
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        in_a = ASIZE'(5);
        in_b = BSIZE'(5);
        #1;
        checkResetOutputs("midrun reset");
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);

        afterReset = vecs[2];
        afterReset.len = 1;
        afterReset.bias = '0;
        afterReset.a[0] = ASIZE'(3);
        afterReset.b[0] = BSIZE'(3);
        afterReset.expData = OUT_W'(9);
        afterReset.expSat = 1'b0;
        applyStimulus(99, afterReset);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
